// File: rtl/vid_pattern_gen.sv
// Raster timing and test-pattern source. Two counters walk the frame,
// a decode stage turns the counter state into timing and pixel values,
// and one output register stage keeps rgb/dv/hs/vs/frame_start aligned.
// A start takes one arming cycle, so the first active pixel appears on
// the second edge after the edge that sampled en_i.
module vid_pattern_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [1:0]  pattern_sel_i,
    input  logic [23:0] solid_rgb_i,
    output logic [23:0] rgb_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    // Counters are at least 8/4 bits wide so the ramp and checker bits exist
    localparam int HW_MIN = $clog2(H_TOTAL);
    localparam int VW_MIN = $clog2(V_TOTAL);
    localparam int HW     = (HW_MIN > 8) ? HW_MIN : 8;
    localparam int VW     = (VW_MIN > 4) ? VW_MIN : 4;
    localparam int BW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [HW-1:0]   h_cnt_r;
    logic [VW-1:0]   v_cnt_r;
    logic [BW-1:0]   bar_pix_r;
    logic [2:0]      bar_idx_r;
    logic [1:0]      sel_r;
    logic [23:0]     solid_r;

    logic            h_last_s;
    logic            v_last_s;
    logic            active_s;
    logic            hs_act_s;
    logic            vs_act_s;
    logic            fs_s;
    logic [23:0]     bar_rgb_s;
    logic [23:0]     pattern_s;
    logic [23:0]     pix_s;

    // Timing decode from the current counter state
    always_comb begin
        h_last_s = (h_cnt_r == H_LAST);
        v_last_s = (v_cnt_r == V_LAST);
        active_s = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
        hs_act_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
        vs_act_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
        fs_s     = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    end

    // Colour-bar lookup, bar index comes from the bar counter
    always_comb begin
        case (bar_idx_r)
            3'd0:    bar_rgb_s = 24'hFFFFFF;
            3'd1:    bar_rgb_s = 24'hFFFF00;
            3'd2:    bar_rgb_s = 24'h00FFFF;
            3'd3:    bar_rgb_s = 24'h00FF00;
            3'd4:    bar_rgb_s = 24'hFF00FF;
            3'd5:    bar_rgb_s = 24'hFF0000;
            3'd6:    bar_rgb_s = 24'h0000FF;
            3'd7:    bar_rgb_s = 24'h000000;
            default: bar_rgb_s = 24'h000000;
        endcase
    end

    // Pattern select on the frame-latched selection, blanked outside active
    always_comb begin
        case (sel_r)
            2'd0:    pattern_s = bar_rgb_s;
            2'd1:    pattern_s = {3{h_cnt_r[7:0]}};
            2'd2:    pattern_s = solid_r;
            2'd3:    pattern_s = (h_cnt_r[3] ^ v_cnt_r[3]) ? 24'hFFFFFF : 24'h000000;
            default: pattern_s = 24'h000000;
        endcase
        if (active_s) begin
            pix_s = pattern_s;
        end else begin
            pix_s = 24'h000000;
        end
    end

    // Control FSM, raster counters and the aligned output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            h_cnt_r       <= {HW{1'b0}};
            v_cnt_r       <= {VW{1'b0}};
            bar_pix_r     <= {BW{1'b0}};
            bar_idx_r     <= 3'd0;
            sel_r         <= 2'd0;
            solid_r       <= 24'h000000;
            rgb_o         <= 24'h000000;
            dv_o          <= 1'b0;
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            frame_start_o <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ARM: begin
                    h_cnt_r       <= {HW{1'b0}};
                    v_cnt_r       <= {VW{1'b0}};
                    bar_pix_r     <= {BW{1'b0}};
                    bar_idx_r     <= 3'd0;
                    rgb_o         <= 24'h000000;
                    dv_o          <= 1'b0;
                    hs_o          <= ~HS_POL;
                    vs_o          <= ~VS_POL;
                    frame_start_o <= 1'b0;
                    if (state_r == ST_ARM) begin
                        state_r <= ST_RUN;
                    end else if (en_i) begin
                        state_r <= ST_ARM;
                        sel_r   <= pattern_sel_i;
                        solid_r <= solid_rgb_i;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rgb_o         <= pix_s;
                    dv_o          <= active_s;
                    hs_o          <= hs_act_s ? HS_POL : ~HS_POL;
                    vs_o          <= vs_act_s ? VS_POL : ~VS_POL;
                    frame_start_o <= fs_s;
                    if (h_last_s) begin
                        h_cnt_r   <= {HW{1'b0}};
                        bar_pix_r <= {BW{1'b0}};
                        bar_idx_r <= 3'd0;
                        if (v_last_s) begin
                            v_cnt_r <= {VW{1'b0}};
                            // Frame boundary: the only point where en_i matters
                            if (en_i) begin
                                sel_r   <= pattern_sel_i;
                                solid_r <= solid_rgb_i;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            v_cnt_r <= v_cnt_r + VW'(1);
                        end
                    end else begin
                        h_cnt_r <= h_cnt_r + HW'(1);
                        if (bar_pix_r == BAR_LAST) begin
                            bar_pix_r <= {BW{1'b0}};
                            bar_idx_r <= bar_idx_r + 3'd1;
                        end else begin
                            bar_pix_r <= bar_pix_r + BW'(1);
                        end
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    rgb_o         <= 24'h000000;
                    dv_o          <= 1'b0;
                    hs_o          <= ~HS_POL;
                    vs_o          <= ~VS_POL;
                    frame_start_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen with a 24x8 raster (16x4 active).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_vid_pattern_gen;

    logic        clk;
    logic        rst;
    logic        en_i;
    logic [1:0]  pattern_sel_i;
    logic [23:0] solid_rgb_i;
    logic [23:0] rgb_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic        frame_start_o;

    int n_chk;
    int n_pass;
    int cur_c;
    logic [23:0] bars [8];

    vid_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .pattern_sel_i (pattern_sel_i),
        .solid_rgb_i   (solid_rgb_i),
        .rgb_o         (rgb_o),
        .dv_o          (dv_o),
        .hs_o          (hs_o),
        .vs_o          (vs_o),
        .frame_start_o (frame_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s c=%0d got=%h exp=%h", tag, cur_c, got, exp);
        end
    endtask

    // Every output must sit at its idle/reset level
    task automatic check_idle(input string tag);
        check({tag, "_dv"}, {23'd0, dv_o}, 24'd0);
        check({tag, "_hs"}, {23'd0, hs_o}, 24'd0);
        check({tag, "_vs"}, {23'd0, vs_o}, 24'd1);
        check({tag, "_fs"}, {23'd0, frame_start_o}, 24'd0);
        check({tag, "_rgb"}, rgb_o, 24'd0);
    endtask

    function automatic logic [23:0] exp_rgb(input logic [1:0] sel, input logic [23:0] solid,
                                            input int h, input int v);
        logic [7:0] hb;
        hb = h[7:0];
        if (!(h < 16 && v < 4)) return 24'h000000;
        case (sel)
            2'd0:    return bars[h / 2];
            2'd1:    return {hb, hb, hb};
            2'd2:    return solid;
            default: return ((((h / 8) % 2) ^ ((v / 8) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    // Start from idle: en_i sampled at edge N, outputs stay idle through N+1
    task automatic start_run(input logic [1:0] sel, input logic [23:0] solid);
        en_i = 1'b1;
        pattern_sel_i = sel;
        solid_rgb_i = solid;
        @(negedge clk);
        check_idle("start_n");
        @(negedge clk);
        check_idle("start_n1");
        @(negedge clk);
    endtask

    // Check 192 consecutive cycles against the raster; optionally change inputs at cycle chg_c
    task automatic check_frame(input logic [1:0] sel, input logic [23:0] solid,
                               input int chg_c, input logic [1:0] nsel,
                               input logic [23:0] nsolid, input logic nen);
        int h;
        int v;
        for (int c = 0; c < 192; c++) begin
            h = c % 24;
            v = c / 24;
            cur_c = c;
            check("dv",  {23'd0, dv_o}, {23'd0, (h < 16 && v < 4) ? 1'b1 : 1'b0});
            check("hs",  {23'd0, hs_o}, {23'd0, (h >= 18 && h <= 20) ? 1'b1 : 1'b0});
            check("vs",  {23'd0, vs_o}, {23'd0, (v == 5 || v == 6) ? 1'b0 : 1'b1});
            check("fs",  {23'd0, frame_start_o}, {23'd0, (c == 0) ? 1'b1 : 1'b0});
            check("rgb", rgb_o, exp_rgb(sel, solid, h, v));
            if (c == chg_c) begin
                pattern_sel_i = nsel;
                solid_rgb_i = nsolid;
                en_i = nen;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cur_c = 0;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        rst = 1'b1;
        en_i = 1'b0;
        pattern_sel_i = 2'd0;
        solid_rgb_i = 24'h000000;

        // Reset held for 4 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // Bars; request ramp mid-frame
        start_run(2'd0, 24'h000000);
        check_frame(2'd0, 24'h000000, 100, 2'd1, 24'h000000, 1'b1);
        // Ramp; switch to solid at line 2, must not show until next frame
        check_frame(2'd1, 24'h000000, 48, 2'd2, 24'h123456, 1'b1);
        // Solid; request checkerboard and a different solid mid-frame
        check_frame(2'd2, 24'h123456, 30, 2'd3, 24'hABCDEF, 1'b1);
        // Checkerboard; drop en_i at line 1, frame must complete
        check_frame(2'd3, 24'hABCDEF, 24, 2'd3, 24'hABCDEF, 1'b0);

        // Idle after the final frame
        for (int i = 0; i < 10; i++) begin
            cur_c = i;
            check_idle("stopped");
            @(negedge clk);
        end

        // Restart, then reset mid-line
        start_run(2'd0, 24'h000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
        end
        cur_c = 5;
        check("midline_dv", {23'd0, dv_o}, 24'd1);
        rst = 1'b1;
        en_i = 1'b0;
        @(negedge clk);
        check_idle("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cur_c = i;
            check("after_rst_dv", {23'd0, dv_o}, 24'd0);
        end

        // New start after reset goes through the full latency again
        start_run(2'd1, 24'h000000);
        check_frame(2'd1, 24'h000000, 0, 2'd1, 24'h000000, 1'b0);
        cur_c = 0;
        check_idle("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
